// File: rtl/mul_div_unit.sv
// mul_div_unit: HI/LO multiply/divide unit.
// Multiplies complete after MUL_LATENCY cycles. Divides use a radix-2
// restoring loop on operand magnitudes, WIDTH steps plus one fix-up cycle.
// HI/LO also accept direct writes (MTHI/MTLO) while the unit is idle.
module mul_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [7:0]       MUL_LAST = 8'(MUL_LATENCY);
  localparam logic [7:0]       DIV_LAST = 8'(WIDTH);

  // Two's-complement negation.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  // Absolute value when the operand is treated as signed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  // Sign- or zero-extension to the double-width product size.
  function automatic logic [2*WIDTH-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    return sgn ? {{WIDTH{v[WIDTH-1]}}, v} : {{WIDTH{1'b0}}, v};
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic [2*WIDTH-1:0] prod_s, acc_s, mul_res_s;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH-1:0]   diff_s;
  logic               ge_s, q_neg_s, r_neg_s;

  // Datapath: multiply/accumulate result and one restoring-divide step.
  always_comb begin
    prod_s    = extend(a_q, ~op_q[0]) * extend(b_q, ~op_q[0]);
    acc_s     = {hi_q, lo_q};
    if (op_q[2]) begin
      mul_res_s = op_q[1] ? (acc_s - prod_s) : (acc_s + prod_s);
    end else begin
      mul_res_s = prod_s;
    end
    shifted_s = {rem_q, quot_q[WIDTH-1]};
    ge_s      = (shifted_s >= {1'b0, dvs_q});
    diff_s    = shifted_s[WIDTH-1:0] - dvs_q;
    q_neg_s   = ~op_q[0] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg_s   = ~op_q[0] & a_q[WIDTH-1];
  end

  // Next-state and register-update logic for the IDLE/MUL/DIV controller.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_we) begin
          hi_d = wdata;
        end else begin
          hi_d = hi_q;
        end
        if (lo_we) begin
          lo_d = wdata;
        end else begin
          lo_d = lo_q;
        end
        if (start && !flush) begin
          op_d = op;
          a_d  = src_a;
          b_d  = src_b;
          if (op[2:1] == 2'b01) begin
            state_d = S_DIV;
            rem_d   = {WIDTH{1'b0}};
            quot_d  = magnitude(src_a, ~op[0]);
            dvs_d   = magnitude(src_b, ~op[0]);
            cnt_d   = 8'd0;
          end else begin
            state_d = S_MUL;
            cnt_d   = 8'd1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          {hi_d, lo_d} = mul_res_s;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == DIV_LAST) begin
          // Fix-up cycle: restore signs, or apply the divide-by-zero result.
          if (b_q == {WIDTH{1'b0}}) begin
            lo_d = ALL_ONES;
            hi_d = a_q;
          end else begin
            lo_d = q_neg_s ? negate(quot_q) : quot_q;
            hi_d = r_neg_s ? negate(rem_q) : rem_q;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          rem_d  = ge_s ? diff_s : shifted_s[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], ge_s};
          cnt_d  = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      quot_q  <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      cnt_q   <= 8'd0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32, MUL_LATENCY=3).
module tb_mul_div_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush, hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int n_vec = 0;
  int n_err = 0;

  mul_div_unit #(.WIDTH(32), .MUL_LATENCY(3)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Request one op; returns between E0 and E1 with operands scrambled.
  task automatic do_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; src_a = 32'hA5A5A5A5; src_b = 32'h5A5A5A5A;
  endtask

  // Direct HI/LO write for one cycle.
  task automatic do_write(input logic wh, input logic wl, input logic [31:0] d);
    @(negedge clk);
    hi_we = wh; lo_we = wl; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Count edges after E0 until done, and busy cycles seen before it.
  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b1; start = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, hi_out, lo_out} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi_out, lo_out);
    end
    resetn = 1'b1;
  endtask

  task automatic test_mult;
    int n, bc;
    do_start(3'b000, 32'hFFFFFFFF, 32'd2);
    wait_done(n, bc);
    n_vec++;
    if (n !== 3 || bc !== 3) begin
      n_err++;
      $display("FAIL mult_latency: done after %0d busy %0d, required 3 and 3", n, bc);
    end
    n_vec++;
    if ({hi_out, lo_out} !== 64'hFFFFFFFF_FFFFFFFE) begin
      n_err++;
      $display("FAIL mult_result: got %h_%h, required ffffffff_fffffffe", hi_out, lo_out);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
    end
    do_start(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n, bc);
    n_vec++;
    if ({hi_out, lo_out} !== 64'hFFFFFFFE_00000001) begin
      n_err++;
      $display("FAIL multu_result: got %h_%h, required fffffffe_00000001", hi_out, lo_out);
    end
  endtask

  task automatic test_div;
    int n, bc;
    logic [2:0]  t_op [6]  = '{3'b011, 3'b010, 3'b010, 3'b010, 3'b010, 3'b011};
    logic [31:0] t_a  [6]  = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'd5, 32'h80000000, 32'h12345678};
    logic [31:0] t_b  [6]  = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [31:0] t_lo [6]  = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] t_hi [6]  = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'd5, 32'd0, 32'h12345678};
    for (int i = 0; i < 6; i++) begin
      do_start(t_op[i], t_a[i], t_b[i]);
      wait_done(n, bc);
      n_vec++;
      if (n !== 33) begin
        n_err++;
        $display("FAIL div_latency[%0d]: done after %0d cycles, required 33", i, n);
      end
      n_vec++;
      if (lo_out !== t_lo[i] || hi_out !== t_hi[i]) begin
        n_err++;
        $display("FAIL div_result[%0d]: lo=%h hi=%h, required lo=%h hi=%h", i, lo_out, hi_out, t_lo[i], t_hi[i]);
      end
    end
  endtask

  task automatic test_madd_msub;
    int n, bc;
    do_write(1'b0, 1'b1, 32'hFFFFFFFF);
    do_write(1'b1, 1'b0, 32'd0);
    n_vec++;
    if ({hi_out, lo_out} !== 64'h00000000_FFFFFFFF) begin
      n_err++;
      $display("FAIL mthi_mtlo: got %h_%h, required 00000000_ffffffff", hi_out, lo_out);
    end
    do_start(3'b101, 32'd1, 32'd1);
    wait_done(n, bc);
    n_vec++;
    if ({hi_out, lo_out} !== 64'h00000001_00000000) begin
      n_err++;
      $display("FAIL maddu_result: got %h_%h, required 00000001_00000000", hi_out, lo_out);
    end
    do_start(3'b110, 32'd1, 32'd1);
    wait_done(n, bc);
    n_vec++;
    if ({hi_out, lo_out} !== 64'h00000000_FFFFFFFF) begin
      n_err++;
      $display("FAIL msub_result: got %h_%h, required 00000000_ffffffff", hi_out, lo_out);
    end
    // MTHI in the same cycle as a MADD start: accumulate onto 0x10_ffffffff.
    @(negedge clk);
    start = 1'b1; op = 3'b100; src_a = 32'd2; src_b = 32'd3; hi_we = 1'b1; wdata = 32'h10;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; src_a = 32'hA5A5A5A5;
    wait_done(n, bc);
    n_vec++;
    if ({hi_out, lo_out} !== 64'h00000011_00000005) begin
      n_err++;
      $display("FAIL madd_with_mthi: got %h_%h, required 00000011_00000005", hi_out, lo_out);
    end
  endtask

  task automatic test_flush;
    logic saw_done;
    do_write(1'b1, 1'b0, 32'h0BAD0001);
    do_write(1'b0, 1'b1, 32'h0BAD0002);
    do_start(3'b011, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b1; op = 3'b000; src_a = 32'd9; src_b = 32'd9; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL div_busy: busy=%b mid-divide, required 1", busy);
    end
    repeat (7) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_busy: busy=%b after flush, required 0", busy);
    end
    saw_done = 1'b0;
    repeat (40) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (saw_done !== 1'b0 || hi_out !== 32'h0BAD0001 || lo_out !== 32'h0BAD0002) begin
      n_err++;
      $display("FAIL flush_state: done_seen=%b hi=%h lo=%h, required 0 0bad0001 0bad0002", saw_done, hi_out, lo_out);
    end
    @(negedge clk);
    start = 1'b1; op = 3'b000; src_a = 32'd2; src_b = 32'd3; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    saw_done = 1'b0;
    repeat (5) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (saw_done !== 1'b0 || lo_out !== 32'h0BAD0002) begin
      n_err++;
      $display("FAIL flush_cancel_start: activity=%b lo=%h, required 0 0bad0002", saw_done, lo_out);
    end
  endtask

  task automatic test_back_to_back;
    int n, bc;
    do_start(3'b001, 32'd6, 32'd7);
    wait_done(n, bc);
    n_vec++;
    if ({hi_out, lo_out} !== 64'd42) begin
      n_err++;
      $display("FAIL b2b_first: got %h_%h, required 00000000_0000002a", hi_out, lo_out);
    end
    start = 1'b1; op = 3'b000; src_a = 32'hFFFFFFFD; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0; src_a = 32'hA5A5A5A5; src_b = 32'h5A5A5A5A;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b after start in done cycle, required 1", busy);
    end
    wait_done(n, bc);
    n_vec++;
    if (n !== 3 || {hi_out, lo_out} !== 64'hFFFFFFFF_FFFFFFF4) begin
      n_err++;
      $display("FAIL b2b_second: n=%0d got %h_%h, required 3 ffffffff_fffffff4", n, hi_out, lo_out);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_vec++;
    if (done !== 1'b0 || {hi_out, lo_out} !== 64'hFFFFFFFF_FFFFFFF4) begin
      n_err++;
      $display("FAIL flush_done_cycle: done=%b got %h_%h, required 0 ffffffff_fffffff4", done, hi_out, lo_out);
    end
  endtask

  task automatic test_reset_mid;
    int n, bc;
    logic saw_done;
    do_start(3'b000, 32'd3, 32'd5);
    @(negedge clk);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi_out, lo_out);
    end
    @(negedge clk);
    resetn = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (saw_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_done: done seen after release=%b, required 0", saw_done);
    end
    do_start(3'b000, 32'd3, 32'd5);
    wait_done(n, bc);
    n_vec++;
    if (n !== 3 || {hi_out, lo_out} !== 64'd15) begin
      n_err++;
      $display("FAIL reset_restart: n=%0d got %h_%h, required 3 00000000_0000000f", n, hi_out, lo_out);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_madd_msub();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
